// File: rtl/window_gen_3x3.sv
// 3x3 neighbourhood generator with zero boundary for raster-order pixel streams.
// A virtual scan one row and one column larger than the image flushes the last
// row/column by injecting zeros; each window is registered and held until taken.
//
//  state | meaning
//  IDLE  | waiting for start, no transfers
//  RUN   | scanning the frame, accepting pixels, emitting windows
//  DONE  | last window taken, frame_done pulses for one cycle
module window_gen_3x3 #(
    parameter int WIDTH = 8,
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [WIDTH:0]       in_pix,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [WIDTH:0]       W1,
    output logic signed [WIDTH:0]       W2,
    output logic signed [WIDTH:0]       W3,
    output logic signed [WIDTH:0]       W4,
    output logic signed [WIDTH:0]       W5,
    output logic signed [WIDTH:0]       W6,
    output logic signed [WIDTH:0]       W7,
    output logic signed [WIDTH:0]       W8,
    output logic signed [WIDTH:0]       W9,
    output logic [$clog2(IMG_H)-1:0]    out_row,
    output logic [$clog2(IMG_W)-1:0]    out_col,
    output logic                        busy,
    output logic                        frame_done
);

    localparam int RW   = $clog2(IMG_H);
    localparam int CW   = $clog2(IMG_W);
    localparam int VR_W = $clog2(IMG_H + 1);
    localparam int VC_W = $clog2(IMG_W + 1);

    localparam logic [VR_W-1:0] VR_LAST  = VR_W'(IMG_H);
    localparam logic [VC_W-1:0] VC_LAST  = VC_W'(IMG_W);
    localparam logic [RW-1:0]   ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0]   COL_LAST = CW'(IMG_W - 1);

    typedef logic signed [WIDTH:0] pix_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [VR_W-1:0] vr;
    logic [VC_W-1:0] vc;
    logic            scan_end;

    // lb_a holds virtual row vr-1, lb_b holds row vr-2, indexed by virtual column
    pix_t lb_a [IMG_W+1];
    pix_t lb_b [IMG_W+1];

    // win[col][row]: col 0 is the oldest column of the sliding window
    pix_t win [3][3];
    pix_t new_col [3];
    pix_t next_w [9];
    pix_t w_q [9];

    logic need_pix;
    logic out_free;
    logic adv;
    logic load;
    logic last_hs;

    // Handshake and step qualification
    always_comb begin
        need_pix = (vr < VR_LAST) && (vc < VC_LAST);
        out_free = !out_valid || out_ready;
        in_ready = (state == RUN) && !scan_end && need_pix && out_free;
        adv      = (state == RUN) && !scan_end && out_free && (!need_pix || in_valid);
        load     = adv && (vr != '0) && (vc != '0);
        last_hs  = out_valid && out_ready && (out_row == ROW_LAST) && (out_col == COL_LAST);
        busy       = (state == RUN);
        frame_done = (state == DONE);
    end

    // Incoming column and masked window candidate for the current step
    always_comb begin
        new_col[0] = lb_b[vc];
        new_col[1] = lb_a[vc];
        new_col[2] = need_pix ? in_pix : '0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                int   rr;
                int   cc;
                pix_t src;
                rr  = int'(vr) - 2 + dr;
                cc  = int'(vc) - 2 + dc;
                src = (dc == 2) ? new_col[dr] : win[dc+1][dr];
                if (rr < 0 || rr >= IMG_H || cc < 0 || cc >= IMG_W)
                    next_w[dr*3+dc] = '0;
                else
                    next_w[dr*3+dc] = src;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_hs) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Virtual scan position; restarted from (0,0) on every accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vr       <= '0;
            vc       <= '0;
            scan_end <= 1'b0;
        end else if (state == IDLE && start) begin
            vr       <= '0;
            vc       <= '0;
            scan_end <= 1'b0;
        end else if (adv) begin
            if (vc == VC_LAST) begin
                vc <= '0;
                if (vr == VR_LAST)
                    scan_end <= 1'b1;
                else
                    vr <= vr + 1'b1;
            end else begin
                vc <= vc + 1'b1;
            end
        end
    end

    // Line buffers; stale contents are hidden by the boundary mask
    always_ff @(posedge clk) begin
        if (adv) begin
            lb_b[vc] <= lb_a[vc];
            lb_a[vc] <= new_col[2];
        end
    end

    // Sliding 3-column window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    win[i][j] <= '0;
        end else if (adv) begin
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= new_col;
        end
    end

    // Output register: loads a new window or drains on out_ready, never bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
            for (int i = 0; i < 9; i++)
                w_q[i] <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_row   <= RW'(vr - 1'b1);
            out_col   <= CW'(vc - 1'b1);
            w_q       <= next_w;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign W1 = w_q[0];
    assign W2 = w_q[1];
    assign W3 = w_q[2];
    assign W4 = w_q[3];
    assign W5 = w_q[4];
    assign W6 = w_q[5];
    assign W7 = w_q[6];
    assign W8 = w_q[7];
    assign W9 = w_q[8];

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3 on a 4x4 image: a zero-padded image model predicts
// every window in raster order; a few literal windows pin the model.
module tb_window_gen_3x3;

    localparam int WIDTH = 8;
    localparam int N     = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [WIDTH:0] in_pix = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic signed [WIDTH:0] W1, W2, W3, W4, W5, W6, W7, W8, W9;
    logic [1:0] out_row, out_col;
    logic busy, frame_done;

    window_gen_3x3 #(.WIDTH(WIDTH), .IMG_W(N), .IMG_H(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
        .out_valid(out_valid), .out_ready(out_ready),
        .W1(W1), .W2(W2), .W3(W3), .W4(W4), .W5(W5),
        .W6(W6), .W7(W7), .W8(W8), .W9(W9),
        .out_row(out_row), .out_col(out_col),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic signed [WIDTH:0] wv [9];
    assign wv[0] = W1; assign wv[1] = W2; assign wv[2] = W3;
    assign wv[3] = W4; assign wv[4] = W5; assign wv[5] = W6;
    assign wv[6] = W7; assign wv[7] = W8; assign wv[8] = W9;

    int img [N][N];
    int tests = 0;
    int fails = 0;
    int widx = 0;
    int pidx = 0;
    int done_cnt = 0;
    bit chk_en = 0;
    bit lit_en = 0;
    bit neg_mode = 0;
    bit stall_mode = 0;

    int lit00 [9] = '{0, 0, 0, 0, 0, 1, 0, 10, 11};
    int lit11 [9] = '{0, 1, 2, 10, 11, 12, 20, 21, 22};
    int lit33 [9] = '{22, 23, 0, 32, 33, 0, 0, 0, 0};
    int lit12 [9] = '{1, 2, 3, 11, 12, 13, 21, 22, 23};

    // Expected element i of window k from the zero-padded image
    function automatic int expw(int k, int i);
        int r, c, rr, cc;
        r  = k / N;
        c  = k % N;
        rr = r - 1 + i / 3;
        cc = c - 1 + i % 3;
        if (rr < 0 || rr >= N || cc < 0 || cc >= N) return 0;
        return img[rr][cc];
    endfunction

    task automatic check_lit(input string name, input int lit [9]);
        int bad = -1;
        tests++;
        for (int i = 0; i < 9; i++)
            if (bad < 0 && int'(wv[i]) != lit[i]) bad = i;
        if (bad >= 0) begin
            fails++;
            $display("FAIL %s W%0d: got %0d expected %0d", name, bad + 1, int'(wv[bad]), lit[bad]);
        end
    endtask

    // Compare process: every presented window against the model
    always @(negedge clk) begin
        if (chk_en) begin
            if (frame_done) done_cnt++;
            if (out_valid) begin
                tests++;
                if (widx >= N * N) begin
                    fails++;
                    $display("FAIL extra_window: got window #%0d at r%0d c%0d, expected none", widx, out_row, out_col);
                end else begin
                    int bad;
                    bad = -1;
                    for (int i = 0; i < 9; i++)
                        if (bad < 0 && int'(wv[i]) != expw(widx, i)) bad = i;
                    if (int'(out_row) != widx / N || int'(out_col) != widx % N) begin
                        fails++;
                        $display("FAIL window_pos #%0d: got r%0d c%0d expected r%0d c%0d",
                                 widx, out_row, out_col, widx / N, widx % N);
                    end else if (bad >= 0) begin
                        fails++;
                        $display("FAIL window_data #%0d W%0d: got %0d expected %0d",
                                 widx, bad + 1, int'(wv[bad]), expw(widx, bad));
                    end
                    if (lit_en && out_row == 0 && out_col == 0) check_lit("lit_w00", lit00);
                    if (lit_en && out_row == 1 && out_col == 1) check_lit("lit_w11", lit11);
                    if (lit_en && out_row == 3 && out_col == 3) check_lit("lit_w33", lit33);
                    if (neg_mode && out_row == 0 && out_col == 0) begin
                        tests++;
                        if (int'(W5) != -256) begin
                            fails++;
                            $display("FAIL neg_w5: got %0d expected -256", int'(W5));
                        end
                    end
                    if (stall_mode && !out_ready) begin
                        check_lit("stall_w12", lit12);
                        tests++;
                        if (in_ready !== 1'b0) begin
                            fails++;
                            $display("FAIL stall_in_ready: got %b expected 0", in_ready);
                        end
                    end
                end
                if (out_ready) widx++;
            end
        end
    end

    task automatic check_all_zero(input string name);
        bit bad;
        bad = (in_ready !== 1'b0) || (out_valid !== 1'b0) || (busy !== 1'b0) ||
              (frame_done !== 1'b0) || (out_row !== 2'd0) || (out_col !== 2'd0);
        for (int i = 0; i < 9; i++) if (wv[i] !== '0) bad = 1;
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL %s: got rdy%b ov%b busy%b fd%b r%0d c%0d W5=%0d expected all 0",
                     name, in_ready, out_valid, busy, frame_done, out_row, out_col, int'(W5));
        end
    endtask

    task automatic run_frame(input bit toggle, input bit stall, input bit restart,
                             input int abort_at);
        int  cyc;
        int  stall_left;
        bit  stall_done;
        bit  restart_done;
        bit  hs;
        int  extra;
        widx = 0; pidx = 0; done_cnt = 0;
        stall_mode = stall; stall_left = 0; stall_done = 0; restart_done = 0;
        chk_en = 1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        in_valid = 1'b1;
        in_pix = 9'(img[0][0]);
        @(posedge clk); #1;
        start = 1'b0;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_after_start: got %b expected 1", busy);
        end
        cyc = 0; extra = -1;
        while (cyc < 500 && extra != 0) begin
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (hs) pidx++;
            if (abort_at >= 0 && pidx == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("reset_mid_frame");
                chk_en = 0;
                in_valid = 1'b0;
                start = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                stall_mode = 0;
                return;
            end
            in_valid = (pidx < N * N) && (!toggle || cyc[0]);
            in_pix   = (pidx < N * N) ? 9'(img[pidx / N][pidx % N]) : '0;
            start    = restart && !restart_done && pidx == 5;
            if (start) restart_done = 1;
            if (stall && !stall_done && out_valid && out_row == 1 && out_col == 2) begin
                out_ready = 1'b0;
                stall_left = 5;
                stall_done = 1;
            end else if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) out_ready = 1'b1;
            end
            if (extra > 0) extra--;
            if (extra < 0 && done_cnt > 0) extra = 3;
        end
        start = 1'b0;
        in_valid = 1'b0;
        tests++;
        if (extra != 0) begin
            fails++;
            $display("FAIL frame_timeout: got %0d windows %0d pixels, expected frame_done", widx, pidx);
        end
        tests++;
        if (widx != N * N || pidx != N * N || done_cnt != 1) begin
            fails++;
            $display("FAIL frame_counts: got %0d windows %0d pixels %0d done, expected 16 16 1",
                     widx, pidx, done_cnt);
        end
        tests++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_frame: got busy%b rdy%b expected 0 0", busy, in_ready);
        end
        if (stall) begin
            tests++;
            if (!stall_done) begin
                fails++;
                $display("FAIL stall_reached: got no window r1 c2 expected stall");
            end
        end
        chk_en = 0;
        stall_mode = 0;
    endtask

    initial begin
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                img[r][c] = 10 * r + c;
        #12;
        check_all_zero("reset_state");
        @(posedge clk); #1;
        rst_n = 1'b1;

        lit_en = 1;
        run_frame(0, 0, 0, -1);
        lit_en = 0;
        run_frame(0, 1, 0, -1);
        run_frame(1, 0, 0, -1);
        run_frame(0, 0, 0, 7);
        lit_en = 1;
        run_frame(0, 0, 0, -1);
        run_frame(1, 0, 1, -1);
        lit_en = 0;

        img[0][0] = -256;
        neg_mode = 1;
        run_frame(0, 0, 0, -1);
        neg_mode = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/window_gen_3x3.md
WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 SHALL have parameter WIDTH, default 8; every pixel is a signed WIDTH+1-bit value ([WIDTH:0]).
REQ-002 SHALL have parameter IMG_W, default 16; image width in pixels, minimum 2.
REQ-003 SHALL have parameter IMG_H, default 16; image height in pixels, minimum 2.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  one-cycle pulse that begins a frame; honoured only in IDLE.
REQ-008 in_valid  input  1  in_pix is valid.
REQ-009 in_ready  output  1  block accepts in_pix this cycle.
REQ-010 in_pix  input  WIDTH+1  signed pixel in raster order (row 0 col 0 first).
REQ-011 out_valid  output  1  window W1..W9 is valid.
REQ-012 out_ready  input  1  downstream cell (A/B template stage) accepts the window.
REQ-013 W1..W9  output  WIDTH+1 each  3x3 neighbourhood, row-major: W1 top-left, W5 centre, W9 bottom-right.
REQ-014 out_row, out_col  output  clog2(IMG_H), clog2(IMG_W)  centre coordinates of the presented window.
REQ-015 busy  output  1  high in RUN.
REQ-016 frame_done  output  1  one-cycle pulse after the last window is accepted.

Function
REQ-017 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE when window (IMG_H-1, IMG_W-1) handshakes; DONE->IDLE unconditionally after one cycle, frame_done high only in DONE.
REQ-018 SHALL walk a virtual scan (vr, vc) over vr = 0..IMG_H, vc = 0..IMG_W, in raster order, one step per advance.
REQ-019 SHALL consume an input pixel on a step when vr < IMG_H and vc < IMG_W; other steps inject zero with no input transfer.
REQ-020 SHALL advance a step only when (input not needed, or in_valid && in_ready) and the output register is free (out_valid low, or out_ready high).
REQ-021 in_ready SHALL be high only in RUN, when the current step needs input and the output register is free.
REQ-022 SHALL hold two line buffers of IMG_W+1 entries plus a 3x3 shift window.
REQ-023 On a step with vr >= 1 and vc >= 1, SHALL register window centred (vr-1, vc-1), set out_valid next cycle, and keep W1..W9, out_row and out_col stable until out_ready.
REQ-024 SHALL force any window element whose image coordinate lies outside 0..IMG_H-1 / 0..IMG_W-1 to zero (zero boundary condition).
REQ-025 SHALL emit exactly IMG_H*IMG_W windows per frame, in raster order of centre.
REQ-026 Latency: window (r,c) SHALL become valid one cycle after pixel (r+1,c+1) is accepted, or after the corresponding zero-injection step on the last row or column.
REQ-027 A simultaneous out_ready handshake and new window load in the same cycle SHALL keep out_valid high with the new window (no bubble).
REQ-028 start during RUN or DONE SHALL be ignored; in_valid outside RUN SHALL be ignored.
REQ-029 Pixels SHALL pass unmodified; no arithmetic, no saturation.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, scan counters 0, in_ready 0, out_valid 0, busy 0, frame_done 0, W1..W9 0, out_row 0, out_col 0.
REQ-031 Line buffer contents need not be cleared; zero masking (REQ-024) SHALL make stale data invisible.
REQ-032 Reset mid-frame SHALL abandon the frame; the next start SHALL begin a fresh frame at pixel (0,0).

Verification (IMG_W=4, IMG_H=4, pixel(r,c)=10r+c)
REQ-033 start, continuous in_valid, out_ready=1 -> 16 windows; window (0,0) = 0,0,0,0,0,1,0,10,11; window (1,1) = 0,1,2,10,11,12,20,21,22; window (3,3) = 22,23,0,32,33,0,0,0,0; frame_done pulses once.
REQ-034 out_ready held low 5 cycles at window (1,2) -> W1..W9 = 1,2,3,11,12,13,21,22,23 stable, in_ready low, no pixels lost.
REQ-035 in_valid toggling every other cycle -> same 16 windows and order as REQ-033.
REQ-036 rst_n low after 7 pixels accepted -> all outputs 0 the same cycle; new start gives window (0,0) identical to REQ-033.
REQ-037 start pulsed during RUN -> ignored; window count remains 16.
REQ-038 Negative pixels (-256 at (0,0)) -> W5 of window (0,0) = -256, sign preserved.
